// File: rtl/hdmi_info_frame_pkg.sv
// Shared types and constants for the runtime-programmable HDMI InfoFrame source.
package hdmi_info_frame_pkg;

   typedef logic [7:0] pb_t;

   localparam logic [6:0] INFO_FRAME_TYPE_AVI   = 7'd2;
   localparam logic [6:0] INFO_FRAME_TYPE_SPD   = 7'd3;
   localparam logic [6:0] INFO_FRAME_TYPE_AUDIO = 7'd4;

   localparam int MAX_PB = 27;

   typedef enum logic [1:0] {IF_IDLE, IF_SUM, IF_LOAD} if_state_t;

   // 8-bit wrapping sum of the three header bytes; seeds the payload checksum
   function automatic pb_t hdr_sum(input logic [23:0] hdr);
      return hdr[7:0] + hdr[15:8] + hdr[23:16];
   endfunction

endpackage

// File: rtl/info_frame_generator_if.sv
// Host-write, commit, frame-timing and packet-picker signals of the InfoFrame source.
interface info_frame_generator_if;
   logic         wr_en;
   logic [4:0]   wr_addr;
   logic [7:0]   wr_data;
   logic         wr_err;
   logic         commit;
   logic         busy;
   logic         frame_start;
   logic         packet_request;
   logic         packet_sent;
   logic [23:0]  header;
   logic [223:0] sub;

   modport master (
      output wr_en, wr_addr, wr_data, commit, frame_start, packet_sent,
      input  wr_err, busy, packet_request, header, sub
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, commit, frame_start, packet_sent,
      output wr_err, busy, packet_request, header, sub
   );
endinterface

// File: rtl/info_frame_checksum.sv
// Seeded 8-bit wrapping accumulator; the parent negates the result into PB0.
module info_frame_checksum
   import hdmi_info_frame_pkg::*;
(
   input  logic clk_pixel,
   input  logic reset_n,
   input  logic clear,
   input  pb_t  seed,
   input  logic add,
   input  pb_t  data,
   output pb_t  result
);

   pb_t acc;

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)   acc <= '0;
      else if (clear) acc <= seed;
      else if (add)   acc <= acc + data;
   end

   assign result = acc;

endmodule

// File: rtl/info_frame_generator.sv
// InfoFrame source: staging buffer, sequential checksum, active buffer, frame scheduler.
// Define INFO_FRAME_ASCII_ZERO_FILTER_EN to store written 8'h30 bytes as 8'h00.
module info_frame_generator
   import hdmi_info_frame_pkg::*;
#(
   parameter logic [6:0] TYPE          = INFO_FRAME_TYPE_SPD,
   parameter logic [7:0] VERSION       = 8'd1,
   parameter logic [4:0] LENGTH        = 5'd25,
   parameter int         REPEAT_FRAMES = 1
) (
   input logic                    clk_pixel,
   input logic                    reset_n,
   info_frame_generator_if.slave  bus
);

   localparam logic [23:0] HDR = {3'b000, LENGTH, VERSION, 1'b1, TYPE};
   localparam pb_t HDR_SUM = hdr_sum(HDR);
   localparam pb_t HDR_CSUM = pb_t'(~HDR_SUM + 8'd1);
   localparam pb_t [MAX_PB:0] ACTIVE_RST = {{MAX_PB{8'h00}}, HDR_CSUM};
   localparam int CNT_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

   if_state_t        state;
   logic [4:0]       idx;
   logic             pending;
   pb_t [MAX_PB:0]   staging;
   pb_t [MAX_PB:0]   active;
   logic             active_valid;
   logic [CNT_W-1:0] frame_cnt;
   pb_t              wr_byte;
   pb_t              acc;
   logic             wr_ok;
   logic             reload;
   logic             sum_clear;

`ifdef INFO_FRAME_ASCII_ZERO_FILTER_EN
   assign wr_byte = (bus.wr_data == 8'h30) ? 8'h00 : bus.wr_data;
`else
   assign wr_byte = bus.wr_data;
`endif

   assign wr_ok     = bus.wr_en && (state == IF_IDLE) &&
                      (bus.wr_addr != 5'd0) && (bus.wr_addr <= LENGTH);
   assign reload    = pending || bus.commit;
   assign sum_clear = ((state == IF_IDLE) && bus.commit) ||
                      ((state == IF_LOAD) && reload);

   info_frame_checksum u_checksum (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .clear     (sum_clear),
      .seed      (HDR_SUM),
      .add       (state == IF_SUM),
      .data      (staging[idx]),
      .result    (acc)
   );

   // PB0 and PB beyond LENGTH are never written, so they stay zero
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n)   staging <= '0;
      else if (wr_ok) staging[bus.wr_addr] <= wr_byte;
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IF_IDLE;
         idx          <= 5'd1;
         pending      <= 1'b0;
         bus.busy     <= 1'b0;
         bus.wr_err   <= 1'b0;
         active       <= ACTIVE_RST;
         active_valid <= 1'b0;
      end else begin
         bus.wr_err <= bus.wr_en && !wr_ok;
         case (state)
            IF_IDLE: begin
               if (bus.commit) begin
                  state    <= IF_SUM;
                  idx      <= 5'd1;
                  bus.busy <= 1'b1;
               end
            end
            IF_SUM: begin
               if (bus.commit) pending <= 1'b1;
               idx <= idx + 5'd1;
               if (idx == LENGTH) state <= IF_LOAD;
            end
            IF_LOAD: begin
               active       <= {staging[MAX_PB:1], pb_t'(~acc + 8'd1)};
               active_valid <= 1'b1;
               pending      <= 1'b0;
               // a commit that arrived during the update restarts it straight away
               if (reload) begin
                  state <= IF_SUM;
                  idx   <= 5'd1;
               end else begin
                  state    <= IF_IDLE;
                  bus.busy <= 1'b0;
               end
            end
            default: state <= IF_IDLE;
         endcase
      end
   end

   // Frame scheduler; a setting frame_start wins over a same-cycle packet_sent
   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt          <= '0;
         bus.packet_request <= 1'b0;
      end else begin
         if (bus.packet_sent) bus.packet_request <= 1'b0;
         if (state == IF_LOAD) begin
            frame_cnt <= '0;
         end else if (bus.frame_start && active_valid) begin
            if (frame_cnt == '0) begin
               bus.packet_request <= 1'b1;
               frame_cnt          <= CNT_W'(REPEAT_FRAMES - 1);
            end else begin
               frame_cnt <= frame_cnt - 1'b1;
            end
         end
      end
   end

   assign bus.header = HDR;
   assign bus.sub    = active;

endmodule

// File: tb/tb_info_frame_generator.sv
// Scoreboard bench for info_frame_generator (LENGTH=25, REPEAT_FRAMES=3).
module tb_info_frame_generator;
   import hdmi_info_frame_pkg::*;

   logic clk_pixel = 1'b0;
   logic reset_n   = 1'b0;

   info_frame_generator_if bus();

   info_frame_generator #(.REPEAT_FRAMES(3)) dut (
      .clk_pixel (clk_pixel),
      .reset_n   (reset_n),
      .bus       (bus)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_checks = 0;
   int n_fail   = 0;

   pb_t          model_stg [1:25];
   logic [223:0] sub_q [$];
   logic         req_q [$];
   logic [223:0] rst_sub;

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk_pixel);
      #1;
   endtask

   function automatic pb_t filt(input pb_t d);
`ifdef INFO_FRAME_ASCII_ZERO_FILTER_EN
      return (d == 8'h30) ? 8'h00 : d;
`else
      return d;
`endif
   endfunction

   function automatic logic [223:0] exp_sub();
      pb_t s;
      logic [223:0] r;
      s = 8'h83 + 8'h01 + 8'h19;
      r = '0;
      for (int k = 1; k <= 25; k++) begin
         s = s + model_stg[k];
         r[8*k +: 8] = model_stg[k];
      end
      r[7:0] = 8'h00 - s;
      return r;
   endfunction

   task automatic wr(input logic [4:0] a, input pb_t d);
      bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
      step();
      bus.wr_en = 1'b0;
      model_stg[a] = filt(d);
   endtask

   // starts at cycle 1 of an update; returns the first cycle with busy low
   task automatic wait_idle(output int cyc);
      cyc = 1;
      while (bus.busy && cyc < 200) begin
         step();
         cyc++;
      end
   endtask

   task automatic frame(input logic sent, input logic exp_req, input string nm);
      logic e;
      bus.frame_start = 1'b1; bus.packet_sent = sent;
      req_q.push_back(exp_req);
      step();
      bus.frame_start = 1'b0; bus.packet_sent = 1'b0;
      e = req_q.pop_front();
      n_checks++;
      if (bus.packet_request !== e) begin
         n_fail++;
         $display("FAIL %s: packet_request=%b expected %b", nm, bus.packet_request, e);
      end
   endtask

   task automatic sent_only();
      bus.packet_sent = 1'b1;
      step();
      bus.packet_sent = 1'b0;
      n_checks++;
      if (bus.packet_request !== 1'b0) begin
         n_fail++;
         $display("FAIL sent_clear: packet_request=%b expected 0", bus.packet_request);
      end
   endtask

   task automatic test_reset();
      bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.commit = 0;
      bus.frame_start = 0; bus.packet_sent = 0;
      for (int k = 1; k <= 25; k++) model_stg[k] = 8'h00;
      rst_sub = exp_sub();
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step();
      n_checks++;
      if (bus.header !== 24'h190183) begin
         n_fail++; $display("FAIL reset_header: got %h expected 190183", bus.header);
      end
      n_checks++;
      if (bus.sub !== rst_sub || bus.sub[7:0] !== 8'h63) begin
         n_fail++; $display("FAIL reset_sub: got %h expected %h", bus.sub, rst_sub);
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.wr_err !== 1'b0 || bus.packet_request !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: busy=%b wr_err=%b req=%b expected 0 0 0",
                  bus.busy, bus.wr_err, bus.packet_request);
      end
      for (int f = 0; f < 4; f++) frame(1'b0, 1'b0, "no_valid_frame");
   endtask

   task automatic test_commit();
      int cyc;
      logic [223:0] e;
      wr(5'd1, 8'h41);
      n_checks++;
      if (bus.sub !== rst_sub) begin
         n_fail++; $display("FAIL staged_not_live: sub=%h expected %h", bus.sub, rst_sub);
      end
      bus.commit = 1'b1;
      sub_q.push_back(exp_sub());
      step();
      bus.commit = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL busy_rise: busy=%b expected 1", bus.busy);
      end
      step(25);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.sub !== rst_sub) begin
         n_fail++; $display("FAIL cycle26: busy=%b sub=%h expected 1 %h", bus.busy, bus.sub, rst_sub);
      end
      wait_idle(cyc);
      cyc = cyc + 25;
      n_checks++;
      if (cyc != 27) begin
         n_fail++; $display("FAIL commit_latency: busy fell at cycle %0d expected 27", cyc);
      end
      e = sub_q.pop_front();
      n_checks++;
      if (bus.sub !== e || bus.sub[7:0] !== 8'h22 || bus.sub[15:8] !== 8'h41) begin
         n_fail++; $display("FAIL commit_sub: got %h expected %h", bus.sub, e);
      end
   endtask

   task automatic test_wr_err();
      int cyc;
      logic [223:0] e;
      logic [4:0] bad [2];
      bad[0] = 5'd0; bad[1] = 5'd26;
      for (int i = 0; i < 2; i++) begin
         bus.wr_en = 1'b1; bus.wr_addr = bad[i]; bus.wr_data = 8'h77;
         step();
         bus.wr_en = 1'b0;
         n_checks++;
         if (bus.wr_err !== 1'b1) begin
            n_fail++; $display("FAIL wr_err_addr%0d: wr_err=%b expected 1", bad[i], bus.wr_err);
         end
         step();
         n_checks++;
         if (bus.wr_err !== 1'b0) begin
            n_fail++; $display("FAIL wr_err_pulse%0d: wr_err=%b expected 0", bad[i], bus.wr_err);
         end
      end
      wr(5'd25, 8'h05);
      n_checks++;
      if (bus.wr_err !== 1'b0) begin
         n_fail++; $display("FAIL wr_ok: wr_err=%b expected 0", bus.wr_err);
      end
      bus.commit = 1'b1;
      sub_q.push_back(exp_sub());
      step();
      bus.commit = 1'b0;
      step();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 8'h55;
      step();
      bus.wr_en = 1'b0;
      n_checks++;
      if (bus.wr_err !== 1'b1) begin
         n_fail++; $display("FAIL wr_err_busy: wr_err=%b expected 1", bus.wr_err);
      end
      wait_idle(cyc);
      e = sub_q.pop_front();
      n_checks++;
      if (cyc >= 200 || bus.sub !== e) begin
         n_fail++; $display("FAIL dropped_writes_sub: got %h expected %h", bus.sub, e);
      end
   endtask

   task automatic test_pending();
      logic [223:0] e;
      wr(5'd3, 8'h10);
      bus.commit = 1'b1;
      sub_q.push_back(exp_sub());
      step();
      bus.commit = 1'b0;
      step(4);
      bus.commit = 1'b1; step(); bus.commit = 1'b0;
      step(3);
      bus.commit = 1'b1; step(); bus.commit = 1'b0;
      step(17);
      e = sub_q.pop_front();
      n_checks++;
      if (bus.busy !== 1'b1 || bus.sub !== e) begin
         n_fail++; $display("FAIL pending_first: busy=%b sub=%h expected 1 %h", bus.busy, bus.sub, e);
      end
      sub_q.push_back(exp_sub());
      step(25);
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL pending_busy52: busy=%b expected 1", bus.busy);
      end
      step();
      e = sub_q.pop_front();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sub !== e) begin
         n_fail++; $display("FAIL pending_second: busy=%b sub=%h expected 0 %h", bus.busy, bus.sub, e);
      end
      step(2);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL pending_collapse: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_write_with_commit();
      int cyc;
      logic [223:0] e;
      logic [7:0] pb2;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd2; bus.wr_data = 8'h30; bus.commit = 1'b1;
      model_stg[2] = filt(8'h30);
      sub_q.push_back(exp_sub());
      step();
      bus.wr_en = 1'b0; bus.commit = 1'b0;
      wait_idle(cyc);
`ifdef INFO_FRAME_ASCII_ZERO_FILTER_EN
      pb2 = 8'h00;
`else
      pb2 = 8'h30;
`endif
      e = sub_q.pop_front();
      n_checks++;
      if (cyc >= 200 || bus.sub !== e || bus.sub[23:16] !== pb2) begin
         n_fail++; $display("FAIL write_with_commit: got %h expected %h", bus.sub, e);
      end
   endtask

   task automatic test_frames();
      frame(1'b0, 1'b1, "frame1");
      step(3);
      n_checks++;
      if (bus.packet_request !== 1'b1) begin
         n_fail++; $display("FAIL request_hold: packet_request=%b expected 1", bus.packet_request);
      end
      sent_only();
      frame(1'b0, 1'b0, "frame2");
      frame(1'b0, 1'b0, "frame3");
      frame(1'b1, 1'b1, "frame4_with_sent");
      sent_only();
      frame(1'b0, 1'b0, "frame5");
      frame(1'b0, 1'b0, "frame6");
      frame(1'b0, 1'b1, "frame7");
      frame(1'b0, 1'b1, "frame8_already_high");
      sent_only();
      frame(1'b0, 1'b0, "frame9_no_queue");
      frame(1'b0, 1'b1, "frame10");
      sent_only();
   endtask

   task automatic test_async_reset();
      int cyc;
      logic [223:0] e;
      frame(1'b0, 1'b0, "frame11");
      frame(1'b0, 1'b0, "frame12");
      frame(1'b0, 1'b1, "frame13");
      wr(5'd7, 8'h99);
      bus.commit = 1'b1; step(); bus.commit = 1'b0;
      step(4);
      #2 reset_n = 1'b0;
      for (int k = 1; k <= 25; k++) model_stg[k] = 8'h00;
      step();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.packet_request !== 1'b0 || bus.wr_err !== 1'b0 ||
          bus.sub !== rst_sub) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b req=%b wr_err=%b sub=%h expected 0 0 0 %h",
                  bus.busy, bus.packet_request, bus.wr_err, bus.sub, rst_sub);
      end
      reset_n = 1'b1;
      step();
      frame(1'b0, 1'b0, "post_reset_frame");
      wr(5'd1, 8'h41);
      bus.commit = 1'b1;
      sub_q.push_back(exp_sub());
      step();
      bus.commit = 1'b0;
      wait_idle(cyc);
      e = sub_q.pop_front();
      n_checks++;
      if (cyc != 27 || bus.sub !== e || bus.sub[7:0] !== 8'h22) begin
         n_fail++;
         $display("FAIL post_reset_commit: cycle=%0d sub=%h expected 27 %h", cyc, bus.sub, e);
      end
   endtask

   initial begin
      test_reset();
      test_commit();
      test_wr_err();
      test_pending();
      test_write_with_commit();
      test_frames();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
